prng_range: RTL and testbench

Downstream consumer and controller for the Lehmer `prng` core (m = 2^31−1, a = 16807). On each request it runs the `prng` start/done handshake and chains every output back as the next seed. It maps the raw draw onto a uniform integer in [0, n) using rejection sampling plus a sequential restoring modulo. It sits between `prng` and any client that needs bounded random indices.

---
 rtl/prng_range.sv | 125 ++++++++++++
 tb/tb_prng_range.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prng_range.sv
// prng_range: bounded uniform draws in [0, n) from a Lehmer prng core; PRNG_RANGE_REJECT_EN enables rejection sampling
module prng_range (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [30:0] range_n,
  input  logic        seed_load,
  input  logic [31:0] seed_init,
  output logic        prng_start,
  output logic        prng_cont,
  output logic [31:0] prng_seed,
  input  logic        prng_done,
  input  logic [31:0] prng_rand,
  output logic        busy,
  output logic        valid,
  output logic [30:0] value,
  output logic        err,
  output logic [7:0]  rejects
);
  typedef enum logic [2:0] {IDLE, THRESH, GEN, REL, CHECK, MOD, OUT} state_t;
`ifdef PRNG_RANGE_REJECT_EN
  localparam state_t FIRST = THRESH;
`else
  localparam state_t FIRST = GEN;
`endif
  state_t      r_state, w_next;
  logic [31:0] r_seed;
  logic [30:0] r_n, r_x, r_div, r_rem, r_value;
  logic [4:0]  r_cnt;
  logic [7:0]  r_rej;
  logic        r_start, r_err;
  logic [31:0] w_shift;
  logic [30:0] w_rem;
  logic        w_div_run, w_last, w_seed_ok, w_reject;
  assign w_div_run = (r_state == THRESH) || (r_state == MOD);
  assign w_last    = (r_cnt == 5'd30);
  assign w_shift   = {r_rem, r_div[30]};
  assign w_rem     = (w_shift >= {1'b0, r_n}) ? 31'(w_shift - {1'b0, r_n}) : w_shift[30:0];
  assign w_seed_ok = (seed_init != 32'd0) && (seed_init < 32'h7FFFFFFF);
`ifdef PRNG_RANGE_REJECT_EN
  logic [30:0] r_limit;
  assign w_reject = (r_x >= r_limit);
  // acceptance limit = (2^31-2) - ((2^31-2) mod n), taken from the last THRESH step
  always_ff @(posedge clk or posedge rst)
    if (rst) r_limit <= 31'd0;
    else if (r_state == THRESH && w_last) r_limit <= 31'h7FFFFFFE - w_rem;
`else
  assign w_reject = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic; the divider shares THRESH and MOD, both 31 steps
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = (range_n == 31'd0) ? OUT : FIRST;
      THRESH:  if (w_last) w_next = GEN;
      GEN:     if (prng_done) w_next = REL;
      REL:     if (!prng_done) w_next = CHECK;
      CHECK:   w_next = w_reject ? GEN : MOD;
      MOD:     if (w_last) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: seed chaining, restoring divider, result and reject counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_start <= 1'b0;
      r_seed  <= 32'd1;
      r_n     <= 31'd0;
      r_x     <= 31'd0;
      r_div   <= 31'd0;
      r_rem   <= 31'd0;
      r_cnt   <= 5'd0;
      r_value <= 31'd0;
      r_err   <= 1'b0;
      r_rej   <= 8'd0;
    end else begin
      r_start <= (w_next == GEN);
      r_cnt   <= w_div_run ? r_cnt + 5'd1 : 5'd0;
      if (w_div_run) begin
        r_rem <= w_rem;
        r_div <= {r_div[29:0], 1'b0};
      end
      if (r_state == IDLE) begin
        if (seed_load && w_seed_ok) r_seed <= seed_init;
        if (req) begin
          r_n   <= range_n;
          r_rej <= 8'd0;
          r_rem <= 31'd0;
          r_div <= 31'h7FFFFFFE;
          if (range_n == 31'd0) begin
            r_value <= 31'd0;
            r_err   <= 1'b1;
          end
        end
      end
      if (r_state == GEN && prng_done) begin
        r_x    <= 31'(prng_rand - 32'd1);
        r_seed <= prng_rand;
      end
      if (r_state == CHECK) begin
        if (w_reject) r_rej <= r_rej + {7'd0, ~&r_rej};
        else begin
          r_rem <= 31'd0;
          r_div <= r_x;
        end
      end
      if (r_state == MOD && w_last) begin
        r_value <= w_rem;
        r_err   <= 1'b0;
      end
    end
  assign prng_start = r_start;
  assign prng_cont  = 1'b0;
  assign prng_seed  = r_seed;
  assign busy       = (r_state != IDLE);
  assign valid      = (r_state == OUT);
  assign value      = r_value;
  assign err        = r_err;
  assign rejects    = r_rej;
endmodule

// File: tb/tb_prng_range.sv
// tb_prng_range: table-driven scoreboard bench for prng_range with a behavioural Lehmer prng responder
module tb_prng_range;
`ifdef PRNG_RANGE_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif
  localparam int LAT      = 3;
  localparam int FULL_LAT = 1 + (REJ ? 31 : 0) + (LAT + 4) + 1 + 31;
  typedef struct {
    logic [30:0] value;
    logic        err;
    logic [7:0]  rejects;
  } exp_t;
  typedef struct {
    logic        ld;
    logic [31:0] seed;
    logic [30:0] n;
    bit          known;
    logic [30:0] val;
    logic        err;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, seed_load = 1'b0;
  logic [30:0] range_n = 31'd0;
  logic [31:0] seed_init = 32'd0;
  logic        prng_start, prng_cont, prng_done = 1'b0;
  logic [31:0] prng_seed, prng_rand = 32'd0;
  logic        busy, valid, err;
  logic [30:0] value;
  logic [7:0]  rejects;
  int          checks = 0, errors = 0, pcnt = 0;
  logic [31:0] m_seed = 32'd1;
  logic [31:0] seed_log[$];
  exp_t        sb[$];
  prng_range dut (
    .clk(clk), .rst(rst), .req(req), .range_n(range_n), .seed_load(seed_load), .seed_init(seed_init),
    .prng_start(prng_start), .prng_cont(prng_cont), .prng_seed(prng_seed), .prng_done(prng_done),
    .prng_rand(prng_rand), .busy(busy), .valid(valid), .value(value), .err(err), .rejects(rejects)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] lehmer(input logic [31:0] s);
    return 32'((longint'(s) * 64'd16807) % 64'd2147483647);
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // reference result of one request; advances the model seed like the real draw chain
  task automatic model(input logic ld, input logic [31:0] s, input logic [30:0] n, output exp_t e);
    longint d, x, lim;
    if (ld && s != 32'd0 && s < 32'h7FFFFFFF) m_seed = s;
    e.value = 31'd0;
    e.err = (n == 31'd0);
    e.rejects = 8'd0;
    if (n != 31'd0) begin
      lim = REJ ? 64'd2147483646 - (64'd2147483646 % n) : 64'd2147483647;
      do begin
        d = longint'(lehmer(m_seed));
        m_seed = 32'(d);
        x = d - 1;
        if (x >= lim && e.rejects != 8'hFF) e.rejects++;
      end while (x >= lim);
      e.value = 31'(x % n);
    end
  endtask
  // prng core stand-in: done rises LAT+1 edges after start, falls one edge after start drops
  always @(posedge clk) begin
    if (!prng_start) begin
      prng_done <= 1'b0;
      pcnt <= 0;
    end else if (!prng_done) begin
      if (pcnt == 0) seed_log.push_back(prng_seed);
      if (pcnt == LAT) begin
        prng_done <= 1'b1;
        prng_rand <= lehmer(prng_seed);
      end else pcnt <= pcnt + 1;
    end
  end
  // scoreboard: every valid pulse must match the oldest pending expectation
  always @(negedge clk)
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got value %0d err %0d, expected no valid", value, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("value", value, e.value);
        chk("err", err, e.err);
        chk("rejects", rejects, e.rejects);
      end
    end
  task automatic issue(input logic ld, input logic [31:0] s, input logic [30:0] n);
    @(negedge clk);
    req = 1'b1;
    seed_load = ld;
    seed_init = s;
    range_n = n;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    seed_load = 1'b0;
  endtask
  // lat counts edges from the req-sampling edge to the one after which valid is seen
  task automatic wait_valid(input bit inject, output int lat);
    lat = 1;
    while (!valid && lat < 6000) begin
      if (inject && lat == 5) begin
        chk("busy_during_op", busy, 1);
        req = 1'b1;
        range_n = 31'd0;
      end
      @(negedge clk);
      req = 1'b0;
      lat++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid after %0d cycles, expected a valid", lat);
    end
  endtask
  task automatic wait_start(input logic want, input string name);
    int k;
    k = 0;
    while (prng_start != want && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, prng_start, want);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, prng_start, 0);
    chk({tag, "_cont"}, prng_cont, 0);
    chk({tag, "_seed"}, prng_seed, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_value"}, value, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rejects"}, rejects, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[10];
    exp_t e;
    int   lat, base;
    vecs[0] = '{1'b1, 32'd1,          31'd10,         1'b1, 31'd6, 1'b0};
    vecs[1] = '{1'b0, 32'd0,          31'd10,         1'b1, 31'd8, 1'b0};
    vecs[2] = '{1'b0, 32'd0,          31'd0,          1'b1, 31'd0, 1'b1};
    vecs[3] = '{1'b1, 32'h7B818935,   31'd1073741825, !REJ, 31'd894907881, 1'b0};
    vecs[4] = '{1'b1, 32'd0,          31'd1,          1'b1, 31'd0, 1'b0};
    vecs[5] = '{1'b1, 32'h7FFFFFFF,   31'd2147483646, 1'b0, 31'd0, 1'b0};
    vecs[6] = '{1'b1, 32'h7FFFFFFE,   31'd7,          1'b0, 31'd0, 1'b0};
    vecs[7] = '{1'b0, 32'd0,          31'd1000,       1'b0, 31'd0, 1'b0};
    vecs[8] = '{1'b0, 32'd0,          31'd3,          1'b0, 31'd0, 1'b0};
    vecs[9] = '{1'b1, 32'd1,          31'd10,         1'b1, 31'd6, 1'b0};
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      base = seed_log.size();
      model(vecs[i].ld, vecs[i].seed, vecs[i].n, e);
      if (vecs[i].known) begin
        e.value = vecs[i].val;
        e.err = vecs[i].err;
      end
      sb.push_back(e);
      issue(vecs[i].ld, vecs[i].seed, vecs[i].n);
      wait_valid(i == 7, lat);
      @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("seed_chain", prng_seed, m_seed);
      if (i == 0) begin
        chk("lat_first", lat, FULL_LAT);
        chk("seed_16807", prng_seed, 32'd16807);
      end
      if (i == 2) begin
        chk("lat_n0", lat, 1);
        chk("n0_no_start", seed_log.size(), base);
      end
      if (i == 3) begin
        chk("reject_first_seed", seed_log.size() > base ? seed_log[base] : 32'd0, 32'h7B818935);
`ifdef PRNG_RANGE_REJECT_EN
        chk("reject_second_seed", seed_log.size() > base + 1 ? seed_log[base + 1] : 32'd0, 32'h755735EB);
        chk("rejects_ge1", rejects >= 8'd1, 1);
`else
        chk("noreject_one_draw", seed_log.size(), base + 1);
        chk("lat_noreject", lat, FULL_LAT);
`endif
      end
    end
    issue(1'b0, 32'd0, 31'd10);
    wait_start(1'b1, "mod_start_hi");
    wait_start(1'b0, "mod_start_lo");
    repeat (8) @(negedge clk);
    chk("value_held", value, 6);
    chk("busy_in_mod", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset("rst_mod");
    @(negedge clk);
    rst = 1'b0;
    m_seed = 32'd1;
    issue(1'b1, 32'd5, 31'd10);
    wait_start(1'b1, "gen_start_hi");
    rst = 1'b1;
    #1;
    chk("rst_gen_start", prng_start, 0);
    chk("rst_gen_seed", prng_seed, 1);
    chk("rst_gen_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    m_seed = 32'd1;
    model(1'b0, 32'd0, 31'd10, e);
    e.value = 31'd6;
    sb.push_back(e);
    issue(1'b0, 32'd0, 31'd10);
    wait_valid(1'b0, lat);
    @(negedge clk);
    chk("lat_after_reset", lat, FULL_LAT);
    chk("seed_after_reset", prng_seed, 32'd16807);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
